// File: rtl/parking_exit_gate.sv
// Exit-side barrier controller for the parking system.
//
// A vehicle at the exit starts a code read. After WAIT_CYCLES the two 2-bit exit
// codes are sampled. A match opens the barrier until sensor_clear arrives or the
// open timer runs out. A mismatch gives a DENIED interval before the read is retried.
// The controller also tracks lot occupancy from entry pulses and confirmed exits.
//
// Optional feature: define PARKING_EXIT_RETRY_LIMIT_EN to count consecutive wrong codes.
// MAX_RETRY wrong codes in a row then lock the gate in ALARM until alarm_ack.
// Without the macro, retries are unlimited and alarm is tied low.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   sensor_exit    vehicle present at the exit barrier
//   sensor_clear   vehicle has passed the barrier
//   car_entered    one-cycle pulse per car admitted by the entry gate
//   alarm_ack      attendant acknowledge, leaves ALARM
//   exit_code_1/2  driver-entered exit code digits
//   gate_open      barrier open command
//   GREEN_LED      status LED, green
//   RED_LED        status LED, red
//   HEX_1, HEX_2   active-low 7-segment digits, bit0=a .. bit6=g
//   occupancy      cars currently in the lot
//   lot_full       occupancy == CAPACITY
//   alarm          high while in ALARM
module parking_exit_gate #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned OPEN_CYCLES = 16,
  parameter int unsigned DENY_CYCLES = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CAPACITY    = 8,
  parameter logic [1:0]  EXIT_CODE_1 = 2'b11,
  parameter logic [1:0]  EXIT_CODE_2 = 2'b00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sensor_exit,
  input  logic                          sensor_clear,
  input  logic                          car_entered,
  input  logic                          alarm_ack,
  input  logic [1:0]                    exit_code_1,
  input  logic [1:0]                    exit_code_2,
  output logic                          gate_open,
  output logic                          GREEN_LED,
  output logic                          RED_LED,
  output logic [6:0]                    HEX_1,
  output logic [6:0]                    HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          lot_full,
  output logic                          alarm
);

  localparam int unsigned OccW = $clog2(CAPACITY + 1);
  localparam int unsigned MaxWO = (WAIT_CYCLES > OPEN_CYCLES) ? WAIT_CYCLES : OPEN_CYCLES;
  localparam int unsigned TimerMax = (MaxWO > DENY_CYCLES) ? MaxWO : DENY_CYCLES;
  localparam int unsigned CntW = $clog2(TimerMax + 1);

  // Active-low segment patterns.
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegP     = 7'b0001100;
  localparam logic [6:0] SegLd    = 7'b0100001;
  localparam logic [6:0] SegG     = 7'b0000010;
  localparam logic [6:0] SegLo    = 7'b0100011;
  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegA     = 7'b0001000;
  localparam logic [6:0] SegL     = 7'b1000111;

  typedef enum logic [2:0] {StIdle, StReadCode, StOpen, StDenied, StAlarm} state_e;

  state_e          state_q, state_d;
  // One timer serves READ_CODE, OPEN and DENIED; it is zeroed on every state change.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            dec;
  logic            code_ok;
  logic            gate_q, green_q, red_q, full_q;
  logic            red_d;
  logic [6:0]      hex1_q, hex2_q, hex1_d, hex2_d;

`ifdef PARKING_EXIT_RETRY_LIMIT_EN
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0] retry_q, retry_d;
  logic              alarm_q;
`else
  logic unused_alarm_ack;
  assign unused_alarm_ack = alarm_ack;
`endif

  assign code_ok = (exit_code_1 == EXIT_CODE_1) && (exit_code_2 == EXIT_CODE_2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec     = 1'b0;
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sensor_exit && (occ_q != '0)) begin
          state_d = StReadCode;
          cnt_d   = '0;
        end
      end
      StReadCode: begin
        if (cnt_q == CntW'(WAIT_CYCLES - 1)) begin
          cnt_d = '0;
          if (code_ok) begin
            state_d = StOpen;
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
            retry_d = '0;
`endif
          end else begin
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
            retry_d = retry_q + RetryW'(1);
            state_d = (retry_d == RetryW'(MAX_RETRY)) ? StAlarm : StDenied;
`else
            state_d = StDenied;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOpen: begin
        if (sensor_clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          dec     = 1'b1;
        end else if (cnt_q == CntW'(OPEN_CYCLES - 1)) begin
          // Timed out: the car backed out, so occupancy is left alone.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDenied: begin
        if (cnt_q == CntW'(DENY_CYCLES - 1)) begin
          cnt_d = '0;
          if (sensor_exit) begin
            state_d = StReadCode;
          end else begin
            state_d = StIdle;
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
            retry_d = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAlarm: begin
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
        if (alarm_ack) begin
          state_d = StIdle;
          retry_d = '0;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Entry and exit in the same cycle cancel, even when the lot is full.
  always_comb begin
    occ_d = occ_q;
    if (dec && (occ_q != '0)) begin
      if (!car_entered) occ_d = occ_q - OccW'(1);
    end else if (car_entered && (occ_q != OccW'(CAPACITY))) begin
      occ_d = occ_q + OccW'(1);
    end
  end

  // Outputs are decoded from the next state so they change together with state_q.
  always_comb begin
    hex1_d = SegBlank;
    hex2_d = SegBlank;
    red_d  = 1'b0;
    unique case (state_d)
      StReadCode: begin hex1_d = SegP; hex2_d = SegLd; red_d = 1'b1; end
      StOpen:     begin hex1_d = SegG; hex2_d = SegLo; end
      StDenied: begin
        hex1_d = SegE;
        hex2_d = SegE;
        red_d  = (state_q == StDenied) ? ~red_q : 1'b1;
      end
      StAlarm:    begin hex1_d = SegA; hex2_d = SegL; red_d = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      occ_q   <= '0;
      gate_q  <= 1'b0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      full_q  <= 1'b0;
      hex1_q  <= SegBlank;
      hex2_q  <= SegBlank;
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
      retry_q <= '0;
      alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      gate_q  <= (state_d == StOpen);
      green_q <= (state_d == StOpen);
      red_q   <= red_d;
      full_q  <= (occ_d == OccW'(CAPACITY));
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
      retry_q <= retry_d;
      alarm_q <= (state_d == StAlarm);
`endif
    end
  end

  assign gate_open = gate_q;
  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;
  assign occupancy = occ_q;
  assign lot_full  = full_q;
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
  assign alarm     = alarm_q;
`else
  assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_parking_exit_gate.sv
// Scoreboard bench for parking_exit_gate (default parameters).
// Stimulus pushes expected output snapshots tagged with the cycle they are due;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_parking_exit_gate;

  logic       clk = 1'b0;
  logic       reset, sensor_exit, sensor_clear, car_entered, alarm_ack;
  logic [1:0] exit_code_1, exit_code_2;
  logic       gate_open, GREEN_LED, RED_LED, lot_full, alarm;
  logic [6:0] HEX_1, HEX_2;
  logic [3:0] occupancy;

  parking_exit_gate dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_exit (sensor_exit),
    .sensor_clear(sensor_clear),
    .car_entered (car_entered),
    .alarm_ack   (alarm_ack),
    .exit_code_1 (exit_code_1),
    .exit_code_2 (exit_code_2),
    .gate_open   (gate_open),
    .GREEN_LED   (GREEN_LED),
    .RED_LED     (RED_LED),
    .HEX_1       (HEX_1),
    .HEX_2       (HEX_2),
    .occupancy   (occupancy),
    .lot_full    (lot_full),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  // Snapshot: {gate, green, red, alarm, full, hex1, hex2, occ}
  typedef struct {
    int          cyc;
    string       name;
    logic [22:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam int StI = 0, StR = 1, StO = 2, StD = 3, StA = 4;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compare every entry that has come due.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic [22:0] act;
        e   = sb.pop_front();
        act = {gate_open, GREEN_LED, RED_LED, alarm, lot_full, HEX_1, HEX_2, occupancy};
        n_checks++;
        if (e.cyc != cyc || act !== e.val) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got gate=%b grn=%b red=%b alm=%b full=%b hex=%b/%b occ=%0d, expected %b/%b/%b/%b/%b hex=%b/%b occ=%0d",
                   e.name, cyc, act[22], act[21], act[20], act[19], act[18], act[17:11],
                   act[10:4], act[3:0], e.val[22], e.val[21], e.val[20], e.val[19],
                   e.val[18], e.val[17:11], e.val[10:4], e.val[3:0]);
        end
      end
    end
  end

  // Build the expected snapshot for a state from hand-written segment constants.
  task automatic expect_st(input string nm, input int st, input logic red, input int occ);
    exp_t e;
    logic [6:0] h1, h2;
    logic g, gr, r, al;
    g = 0; gr = 0; r = 0; al = 0; h1 = 7'h7F; h2 = 7'h7F;
    case (st)
      StR: begin r = 1; h1 = 7'b0001100; h2 = 7'b0100001; end
      StO: begin g = 1; gr = 1; h1 = 7'b0000010; h2 = 7'b0100011; end
      StD: begin r = red; h1 = 7'b0000110; h2 = 7'b0000110; end
      StA: begin r = 1; al = 1; h1 = 7'b0001000; h2 = 7'b1000111; end
      default: ;
    endcase
    e.cyc  = cyc;
    e.name = nm;
    e.val  = {g, gr, r, al, (occ == 8), h1, h2, 4'(occ)};
    sb.push_back(e);
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Exit with the valid code; leaves the DUT in its first OPEN cycle.
  task automatic exit_to_open();
    exit_code_1 = 2'b11; exit_code_2 = 2'b00;
    sensor_exit = 1; tk(1);
    sensor_exit = 0; tk(4);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; sensor_exit = 0; sensor_clear = 0; car_entered = 0; alarm_ack = 0;
    exit_code_1 = 2'b00; exit_code_2 = 2'b00;
    tk(3);
    expect_st("reset", StI, 0, 0);
    reset = 0;

    // Valid exit.
    car_entered = 1; tk(3); car_entered = 0;
    expect_st("occ3", StI, 0, 3);
    exit_code_1 = 2'b11; exit_code_2 = 2'b00;
    sensor_exit = 1; tk(1);
    expect_st("read_entry", StR, 1, 3);
    sensor_exit = 0; tk(3);
    expect_st("read_no_abort", StR, 1, 3);
    tk(1);
    expect_st("open_after_5", StO, 0, 3);
    sensor_clear = 1; tk(1); sensor_clear = 0;
    expect_st("clear_dec", StI, 0, 2);

    // Alarm path from occupancy 1.
    exit_to_open();
    sensor_clear = 1; tk(1); sensor_clear = 0;
    expect_st("occ1", StI, 0, 1);
    exit_code_1 = 2'b10; exit_code_2 = 2'b01;
    sensor_exit = 1; tk(1);
    expect_st("bad_read", StR, 1, 1);
    tk(4);
    expect_st("deny1_red1", StD, 1, 1);
    tk(1);
    expect_st("deny1_red0", StD, 0, 1);
    tk(2);
    expect_st("deny1_last", StD, 0, 1);
    tk(1);
    expect_st("deny_retry", StR, 1, 1);
    tk(4);
    expect_st("deny2", StD, 1, 1);
    tk(4);
    tk(4);
`ifdef PARKING_EXIT_RETRY_LIMIT_EN
    expect_st("alarm", StA, 1, 1);
    sensor_exit = 0; tk(2);
    expect_st("alarm_hold", StA, 1, 1);
    alarm_ack = 1; tk(1); alarm_ack = 0;
    expect_st("alarm_ack", StI, 0, 1);
`else
    expect_st("deny3_no_alarm", StD, 1, 1);
    sensor_exit = 0; alarm_ack = 1; tk(4); alarm_ack = 0;
    expect_st("deny_to_idle", StI, 0, 1);
`endif

    // Open timeout; sensor_clear outside OPEN must be ignored.
    exit_code_1 = 2'b11; exit_code_2 = 2'b00;
    sensor_exit = 1; tk(1);
    sensor_exit = 0; sensor_clear = 1; tk(4); sensor_clear = 0;
    expect_st("to_open", StO, 0, 1);
    tk(15);
    expect_st("open_16th", StO, 0, 1);
    tk(1);
    expect_st("timeout_idle", StI, 0, 1);

    // Saturation and simultaneous entry/exit.
    car_entered = 1; tk(7);
    expect_st("sat_reach", StI, 0, 8);
    tk(2); car_entered = 0;
    expect_st("sat_drop", StI, 0, 8);
    exit_to_open();
    sensor_clear = 1; car_entered = 1; tk(1); sensor_clear = 0; car_entered = 0;
    expect_st("simul", StI, 0, 8);

    // First-cycle sensor_clear honoured.
    exit_to_open();
    sensor_clear = 1; tk(1); sensor_clear = 0;
    expect_st("clear_first", StI, 0, 7);

    // Mid-operation reset, then empty lot.
    exit_to_open();
    expect_st("pre_reset", StO, 0, 7);
    reset = 1; car_entered = 1; tk(1); reset = 0; car_entered = 0;
    expect_st("mid_reset", StI, 0, 0);
    sensor_exit = 1; tk(1);
    expect_st("empty_idle", StI, 0, 0);
    tk(2); sensor_exit = 0;
    expect_st("empty_hold", StI, 0, 0);

    tk(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
